// File: rtl/lsu.sv
// lsu -- load/store unit, requesting end of the data-cache interface.
//
// Accepts one memory operation at a time from execute, issues a single-cycle
// cache request, waits for the cache response and hands load data to
// writeback. The front of the pipeline is stalled while an operation is
// outstanding.
//
// Optional feature macro: LSU_TIMEOUT_EN. When it is defined, a WAIT-cycle
// counter aborts operations the cache never answers. Default build: no
// counter, and timeout_err reads 0.
//
// Ports
//   clk, n_rst          clock, async active-low reset
//   ex_valid/ex_ready   execute handshake (ready only in IDLE)
//   ex_mem_op           MEM_LOAD / MEM_STORE; anything else retires as a no-op
//   ex_address/ex_data  byte address / store data
//   ex_rd               load destination register
//   dc_req              cache request bundle (valid, address, mem_op, data)
//   dc_rsp              cache response bundle (valid, data)
//   wb_valid/wb_ready   writeback handshake, held for the whole RESP state
//   wb_data/wb_rd       load result and destination
//   stall               high whenever not IDLE
//   timeout_err         sticky abort flag

package nand_cpu_pkg;
    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2,
        MEM_FENCE = 2'd3
    } MEM_OP;
endpackage

interface d_cache_input_ifc;
    logic                valid;
    logic [15:0]         address;
    nand_cpu_pkg::MEM_OP mem_op;
    logic [15:0]         data;
    modport out (output valid, address, mem_op, data);
    modport in  (input  valid, address, mem_op, data);
endinterface

interface d_cache_output_ifc;
    logic        valid;
    logic [15:0] data;
    modport out (output valid, data);
    modport in  (input  valid, data);
endinterface

module lsu
    import nand_cpu_pkg::*;
#(
    parameter int RD_W           = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  MEM_OP               ex_mem_op,
    input  logic [15:0]         ex_address,
    input  logic [15:0]         ex_data,
    input  logic [RD_W-1:0]     ex_rd,
    d_cache_input_ifc.out       dc_req,
    d_cache_output_ifc.in       dc_rsp,
    output logic                wb_valid,
    output logic [15:0]         wb_data,
    output logic [RD_W-1:0]     wb_rd,
    input  logic                wb_ready,
    output logic                stall,
    output logic                timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t          state, state_next;
    MEM_OP           op_q;
    logic [15:0]     addr_q;
    logic [15:0]     data_q;
    logic [RD_W-1:0] rd_q;
    logic [15:0]     wb_data_q;
    logic            req_valid;
    logic            is_mem;
    logic            accept;
    logic            to_fire;   // WAIT expires this cycle with no response

    assign is_mem = (ex_mem_op == MEM_LOAD) || (ex_mem_op == MEM_STORE);
    // ex_ready is exactly (state == S_IDLE), so the handshake reduces to this.
    assign accept = (state == S_IDLE) && ex_valid && is_mem;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             to_flag;

    // wait_cnt holds the number of WAIT cycles already completed, so the
    // TIMEOUT_CYCLES-th WAIT cycle is the one where it equals TIMEOUT_CYCLES-1.
    // A response in that cycle wins over the abort.
    assign to_fire = (state == S_WAIT) && !dc_rsp.valid &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wait_cnt <= '0;
            to_flag  <= 1'b0;
        end else begin
            if (state == S_REQ)
                wait_cnt <= '0;
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (to_fire)
                to_flag <= 1'b1;
        end
    end

    assign timeout_err = to_flag;
`else
    assign to_fire = 1'b0;
    // The feature is compiled out. The compare is constant-false for any
    // legal TIMEOUT_CYCLES and keeps the parameter referenced.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (accept) state_next = S_REQ;
            S_REQ:  state_next = S_WAIT;
            S_WAIT: if (dc_rsp.valid || to_fire)
                        state_next = (op_q == MEM_LOAD) ? S_RESP : S_IDLE;
            S_RESP: if (wb_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        ex_ready  = 1'b0;
        stall     = 1'b1;
        req_valid = 1'b0;
        wb_valid  = 1'b0;
        unique case (state)
            S_IDLE: begin ex_ready = 1'b1; stall = 1'b0; end
            S_REQ:  req_valid = 1'b1;
            S_RESP: wb_valid  = 1'b1;
            default: ;
        endcase
    end

    // Operation latches. Request fields stay at the last issued operation
    // until the next accept, which covers REQ through the end of WAIT.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            op_q      <= MEM_NONE;
            addr_q    <= '0;
            data_q    <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
        end else begin
            if (accept) begin
                op_q   <= ex_mem_op;
                addr_q <= ex_address;
                data_q <= ex_data;
                rd_q   <= ex_rd;
            end
            // Only a load captures response data; a store's response is dropped.
            if (state == S_WAIT && op_q == MEM_LOAD) begin
                if (dc_rsp.valid)
                    wb_data_q <= dc_rsp.data;
                else if (to_fire)
                    wb_data_q <= '0;
            end
        end
    end

    assign dc_req.valid   = req_valid;
    assign dc_req.address = addr_q;
    assign dc_req.mem_op  = op_q;
    assign dc_req.data    = data_q;
    assign wb_data        = wb_data_q;
    assign wb_rd          = rd_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu -- self-checking bench for lsu. Directed scenarios plus a
// randomized transaction stream checked against a transaction-level model.
module tb_lsu;
    import nand_cpu_pkg::*;

`ifdef LSU_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif
    localparam int RD_W = 3;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic            ex_valid = 1'b0;
    logic            ex_ready;
    MEM_OP           ex_mem_op = MEM_NONE;
    logic [15:0]     ex_address = '0;
    logic [15:0]     ex_data = '0;
    logic [RD_W-1:0] ex_rd = '0;
    logic            wb_valid;
    logic [15:0]     wb_data;
    logic [RD_W-1:0] wb_rd;
    logic            wb_ready = 1'b0;
    logic            stall;
    logic            timeout_err;
    int              errors = 0;
    int              checks = 0;

    d_cache_input_ifc  req();
    d_cache_output_ifc rsp();

    always #5 clk = ~clk;

    lsu #(.RD_W(RD_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .n_rst(n_rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_mem_op(ex_mem_op),
        .ex_address(ex_address), .ex_data(ex_data), .ex_rd(ex_rd),
        .dc_req(req), .dc_rsp(rsp),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_ready(wb_ready),
        .stall(stall), .timeout_err(timeout_err)
    );

    task automatic drive(input MEM_OP op, input logic [15:0] a, input logic [15:0] d,
                         input logic [RD_W-1:0] rd);
        ex_valid = 1'b1; ex_mem_op = op; ex_address = a; ex_data = d; ex_rd = rd;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; wb_ready = 1'b0; ex_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req.valid, req.address, req.data, req.mem_op} !== {1'b0, 16'h0, 16'h0, MEM_NONE}) begin
            errors++; $display("FAIL reset_req: got %h want 0/0/0/NONE", {req.valid, req.address, req.data, req.mem_op});
        end
        checks++;
        if ({wb_valid, wb_data, wb_rd, stall, timeout_err, ex_ready} !== {1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL reset_out: wb_valid=%0b wb_data=%h wb_rd=%0d stall=%0b to=%0b ex_ready=%0b want 0/0/0/0/0/1",
                               wb_valid, wb_data, wb_rd, stall, timeout_err, ex_ready);
        end
        n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ex_ready, stall, req.valid} !== 3'b100) begin
            errors++; $display("FAIL reset_release: ex_ready/stall/req.valid=%b want 100", {ex_ready, stall, req.valid});
        end
    endtask

    task automatic test_load_basic();
        drive(MEM_LOAD, 16'h0040, 16'h0000, 3'd5);
        @(negedge clk);  // cycle 1
        checks++;
        if ({req.valid, req.address, req.mem_op, stall, ex_ready} !== {1'b1, 16'h0040, MEM_LOAD, 1'b1, 1'b0}) begin
            errors++; $display("FAIL load_req: valid=%0b addr=%h op=%0d stall=%0b ex_ready=%0b want 1/0040/LOAD/1/0",
                               req.valid, req.address, req.mem_op, stall, ex_ready);
        end
        ex_valid = 1'b0;
        @(negedge clk);  // cycle 2, WAIT
        checks++;
        if ({req.valid, wb_valid} !== 2'b00) begin
            errors++; $display("FAIL load_wait: req.valid=%0b wb_valid=%0b want 0/0", req.valid, wb_valid);
        end
        rsp.valid = 1'b1; rsp.data = 16'hBEEF;
        @(negedge clk);  // cycle 3, RESP
        checks++;
        if ({wb_valid, wb_data, wb_rd} !== {1'b1, 16'hBEEF, 3'd5}) begin
            errors++; $display("FAIL load_wb: wb_valid=%0b wb_data=%h wb_rd=%0d want 1/beef/5", wb_valid, wb_data, wb_rd);
        end
        rsp.valid = 1'b0; wb_ready = 1'b1;
        @(negedge clk);  // cycle 4
        checks++;
        if ({ex_ready, wb_valid, stall} !== 3'b100) begin
            errors++; $display("FAIL load_done: ex_ready/wb_valid/stall=%b want 100", {ex_ready, wb_valid, stall});
        end
        wb_ready = 1'b0;
    endtask

    task automatic test_store();
        drive(MEM_STORE, 16'h0002, 16'h1234, 3'd0);
        @(negedge clk);  // cycle 1
        checks++;
        if ({req.valid, stall} !== 2'b11) begin
            errors++; $display("FAIL store_req: valid/stall=%b want 11", {req.valid, stall});
        end
        ex_valid = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if ({req.valid, req.address, req.data, req.mem_op, stall, wb_valid} !==
                {1'b0, 16'h0002, 16'h1234, MEM_STORE, 1'b1, 1'b0}) begin
                errors++; $display("FAIL store_hold c%0d: valid=%0b addr=%h data=%h op=%0d stall=%0b wb_valid=%0b want 0/0002/1234/STORE/1/0",
                                   c, req.valid, req.address, req.data, req.mem_op, stall, wb_valid);
            end
            if (c == 6) begin rsp.valid = 1'b1; rsp.data = 16'hFFFF; end
        end
        @(negedge clk);  // cycle 7
        rsp.valid = 1'b0;
        checks++;
        if ({ex_ready, stall, wb_valid} !== 3'b100) begin
            errors++; $display("FAIL store_done: ex_ready/stall/wb_valid=%b want 100", {ex_ready, stall, wb_valid});
        end
    endtask

    task automatic test_wb_hold();
        drive(MEM_LOAD, 16'h0100, 16'h0000, 3'd6);
        @(negedge clk);  // cycle 1
        ex_valid = 1'b0;
        @(negedge clk);  // cycle 2
        rsp.valid = 1'b1; rsp.data = 16'hA55A;
        @(negedge clk);  // cycle 3: RESP begins; present a new store that must wait
        rsp.valid = 1'b0;
        drive(MEM_STORE, 16'h0200, 16'h0BAD, 3'd1);
        for (int c = 3; c <= 7; c++) begin
            if (c > 3) @(negedge clk);
            checks++;
            if ({wb_valid, wb_data, wb_rd, ex_ready, stall, req.valid} !== {1'b1, 16'hA55A, 3'd6, 1'b0, 1'b1, 1'b0}) begin
                errors++; $display("FAIL wb_hold c%0d: wb_valid=%0b data=%h rd=%0d ex_ready=%0b stall=%0b req=%0b want 1/a55a/6/0/1/0",
                                   c, wb_valid, wb_data, wb_rd, ex_ready, stall, req.valid);
            end
        end
        wb_ready = 1'b1;
        @(negedge clk);  // cycle 8: IDLE, pending store accepted at next edge
        checks++;
        if ({ex_ready, wb_valid, req.valid} !== 3'b100) begin
            errors++; $display("FAIL wb_release: ex_ready/wb_valid/req=%b want 100", {ex_ready, wb_valid, req.valid});
        end
        @(negedge clk);  // cycle 9
        checks++;
        if ({req.valid, req.address, req.data, req.mem_op} !== {1'b1, 16'h0200, 16'h0BAD, MEM_STORE}) begin
            errors++; $display("FAIL wb_next_req: valid=%0b addr=%h data=%h op=%0d want 1/0200/0bad/STORE",
                               req.valid, req.address, req.data, req.mem_op);
        end
        ex_valid = 1'b0; wb_ready = 1'b0;
        @(negedge clk);  // cycle 10
        rsp.valid = 1'b1;
        @(negedge clk);
        rsp.valid = 1'b0;
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++; $display("FAIL wb_next_done: ex_ready=%0b want 1", ex_ready);
        end
    endtask

    task automatic test_spurious();
        rsp.valid = 1'b1; rsp.data = 16'hDEAD;
        @(negedge clk);
        checks++;
        if ({ex_ready, stall, wb_valid} !== 3'b100) begin
            errors++; $display("FAIL spur_idle: ex_ready/stall/wb_valid=%b want 100", {ex_ready, stall, wb_valid});
        end
        rsp.data = 16'hBAD1;
        drive(MEM_LOAD, 16'h0300, 16'h0000, 3'd2);
        @(negedge clk);  // cycle 1, REQ with response valid coincident
        ex_valid = 1'b0;
        @(negedge clk);  // cycle 2, WAIT
        rsp.valid = 1'b0;
        @(negedge clk);  // cycle 3, still WAIT if REQ response was ignored
        checks++;
        if ({wb_valid, stall} !== 2'b01) begin
            errors++; $display("FAIL spur_req: wb_valid/stall=%b want 01", {wb_valid, stall});
        end
        rsp.valid = 1'b1; rsp.data = 16'h5A5A;
        @(negedge clk);
        rsp.valid = 1'b0;
        checks++;
        if ({wb_valid, wb_data, wb_rd} !== {1'b1, 16'h5A5A, 3'd2}) begin
            errors++; $display("FAIL spur_real: wb_valid=%0b data=%h rd=%0d want 1/5a5a/2", wb_valid, wb_data, wb_rd);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive(MEM_LOAD, 16'h0700, 16'h0000, 3'd4);
        wb_ready = 1'b1; rsp.valid = 1'b1; rsp.data = 16'hC0DE;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            checks++;
            if ({req.valid, wb_valid, ex_ready} !== {(c % 4) == 1, (c % 4) == 3, (c % 4) == 0}) begin
                errors++; $display("FAIL b2b c%0d: req/wb_valid/ex_ready=%b want %b", c,
                                   {req.valid, wb_valid, ex_ready}, {(c % 4) == 1, (c % 4) == 3, (c % 4) == 0});
            end
            if ((c % 4) == 3) begin
                checks++;
                if (wb_data !== 16'hC0DE) begin
                    errors++; $display("FAIL b2b_data c%0d: wb_data=%h want c0de", c, wb_data);
                end
            end
        end
        ex_valid = 1'b0; wb_ready = 1'b0; rsp.valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        drive(MEM_LOAD, 16'h0400, 16'h0000, 3'd7);
        @(negedge clk);  // cycle 1
        ex_valid = 1'b0;
        @(negedge clk);  // cycle 2, WAIT
        n_rst = 1'b0;
        #1;
        checks++;
        if ({stall, ex_ready, req.valid, req.address, req.mem_op, wb_valid, wb_data, wb_rd} !==
            {1'b0, 1'b1, 1'b0, 16'h0, MEM_NONE, 1'b0, 16'h0, 3'd0}) begin
            errors++; $display("FAIL rst_mid: stall=%0b ex_ready=%0b req=%0b addr=%h op=%0d wb_valid=%0b data=%h rd=%0d want reset values",
                               stall, ex_ready, req.valid, req.address, req.mem_op, wb_valid, wb_data, wb_rd);
        end
        @(negedge clk);
        n_rst = 1'b1; rsp.valid = 1'b1; rsp.data = 16'h7777;
        @(negedge clk);
        rsp.valid = 1'b0;
        checks++;
        if ({ex_ready, stall, wb_valid, wb_data} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
            errors++; $display("FAIL rst_late_rsp: ex_ready=%0b stall=%0b wb_valid=%0b data=%h want 1/0/0/0000",
                               ex_ready, stall, wb_valid, wb_data);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++; $display("FAIL rst_after: wb_valid=%0b want 0", wb_valid);
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            drive(MEM_LOAD, 16'h0500, 16'h0000, 3'd1);
            @(negedge clk);  // cycle 1
            ex_valid = 1'b0;
            for (int w = 1; w <= 8; w++) begin
                @(negedge clk);  // WAIT cycle w
                checks++;
                if ({stall, wb_valid, timeout_err} !== {1'b1, 1'b0, pass == 1}) begin
                    errors++; $display("FAIL to_wait p%0d w%0d: stall/wb_valid/to=%b want 1,0,%0b", pass, w,
                                       {stall, wb_valid, timeout_err}, pass == 1);
                end
                if (pass == 1 && w == 8) begin rsp.valid = 1'b1; rsp.data = 16'h4321; end
            end
            @(negedge clk);
            rsp.valid = 1'b0;
            checks++;
            if ({wb_valid, wb_data, timeout_err} !== {1'b1, (pass == 1) ? 16'h4321 : 16'h0000, 1'b1}) begin
                errors++; $display("FAIL to_resp p%0d: wb_valid=%0b data=%h to=%0b want 1/%h/1", pass, wb_valid, wb_data,
                                   timeout_err, (pass == 1) ? 16'h4321 : 16'h0000);
            end
            wb_ready = 1'b1;
            @(negedge clk);
            wb_ready = 1'b0;
            checks++;
            if ({ex_ready, timeout_err} !== 2'b11) begin
                errors++; $display("FAIL to_sticky p%0d: ex_ready/to=%b want 11", pass, {ex_ready, timeout_err});
            end
        end
        // Clear the sticky flag so later tests see a clean unit.
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask
`else
    task automatic test_no_timeout();
        drive(MEM_LOAD, 16'h0500, 16'h0000, 3'd1);
        @(negedge clk);
        ex_valid = 1'b0;
        for (int w = 1; w <= 80; w++) begin
            @(negedge clk);
            if (w % 20 == 0) begin
                checks++;
                if ({stall, wb_valid, timeout_err} !== 3'b100) begin
                    errors++; $display("FAIL no_to w%0d: stall/wb_valid/to=%b want 100", w, {stall, wb_valid, timeout_err});
                end
            end
        end
        rsp.valid = 1'b1; rsp.data = 16'h2468;
        @(negedge clk);
        rsp.valid = 1'b0;
        checks++;
        if ({wb_valid, wb_data} !== {1'b1, 16'h2468}) begin
            errors++; $display("FAIL no_to_resp: wb_valid=%0b data=%h want 1/2468", wb_valid, wb_data);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
    endtask
`endif

    // Transaction-level model: each op is a record; expected request fields,
    // response data and cycle-by-cycle phase come from its op/latency/hold.
    task automatic test_random();
        MEM_OP last_op = MEM_NONE;
        bit    have_last = 1'b0;
        for (int t = 0; t < 40; t++) begin
            int unsigned     r     = $urandom_range(0, 9);
            MEM_OP           op    = (r < 4) ? MEM_LOAD : (r < 8) ? MEM_STORE : (r == 8) ? MEM_NONE : MEM_FENCE;
            logic [15:0]     a     = 16'($urandom);
            logic [15:0]     d     = 16'($urandom);
            logic [15:0]     rdata = 16'($urandom);
            logic [RD_W-1:0] rd    = RD_W'($urandom);
            int unsigned     lat   = $urandom_range(1, 6);
            int unsigned     hold  = $urandom_range(0, 3);
            checks++;
            if (ex_ready !== 1'b1) begin
                errors++; $display("FAIL rnd_idle t%0d: ex_ready=%0b want 1", t, ex_ready);
            end
            drive(op, a, d, rd);
            rsp.valid = 1'($urandom_range(0, 1)); rsp.data = ~rdata;
            @(negedge clk);  // cycle 1
            ex_valid = 1'b0;
            rsp.valid = 1'b0;
            if (op != MEM_LOAD && op != MEM_STORE) begin
                checks++;
                if ({req.valid, stall, ex_ready} !== 3'b001 || (have_last && req.mem_op !== last_op)) begin
                    errors++; $display("FAIL rnd_noop t%0d: req/stall/ex_ready=%b op=%0d want 001 op=%0d", t,
                                       {req.valid, stall, ex_ready}, req.mem_op, last_op);
                end
                continue;
            end
            checks++;
            if ({req.valid, req.address, req.data, req.mem_op} !== {1'b1, a, d, op}) begin
                errors++; $display("FAIL rnd_req t%0d: got %h want %h", t,
                                   {req.valid, req.address, req.data, req.mem_op}, {1'b1, a, d, op});
            end
            last_op = op; have_last = 1'b1;
            for (int unsigned w = 1; w <= lat; w++) begin
                @(negedge clk);
                checks++;
                if ({req.valid, stall, wb_valid, req.address, req.data, req.mem_op} !== {1'b0, 1'b1, 1'b0, a, d, op}) begin
                    errors++; $display("FAIL rnd_wait t%0d w%0d: got %h want %h", t, w,
                                       {req.valid, stall, wb_valid, req.address, req.data, req.mem_op},
                                       {1'b0, 1'b1, 1'b0, a, d, op});
                end
                if (w == lat) begin rsp.valid = 1'b1; rsp.data = rdata; end
            end
            @(negedge clk);
            rsp.valid = 1'b0;
            if (op == MEM_LOAD) begin
                for (int unsigned h = 0; h <= hold; h++) begin
                    checks++;
                    if ({wb_valid, wb_data, wb_rd, stall} !== {1'b1, rdata, rd, 1'b1}) begin
                        errors++; $display("FAIL rnd_wb t%0d h%0d: valid=%0b data=%h rd=%0d stall=%0b want 1/%h/%0d/1",
                                           t, h, wb_valid, wb_data, wb_rd, stall, rdata, rd);
                    end
                    wb_ready = (h == hold);
                    @(negedge clk);
                end
                wb_ready = 1'b0;
            end
            checks++;
            if ({ex_ready, stall, wb_valid} !== 3'b100) begin
                errors++; $display("FAIL rnd_done t%0d: ex_ready/stall/wb_valid=%b want 100", t, {ex_ready, stall, wb_valid});
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rsp.valid = 1'b0; rsp.data = 16'h0;
        test_reset();
        test_load_basic();
        test_store();
        test_wb_hold();
        test_spurious();
        test_back_to_back();
        test_reset_mid();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
